// File: rtl/hiscore_ram_arb_pkg.sv
// Shared types and default sizing for the high-score work-RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: arb_state_t (arbiter FSM states), ARB_AW / ARB_SETTLE defaults.
package hiscore_arb_pkg;

  localparam int ARB_AW     = 10;  // work RAM address width (1 KiB)
  localparam int ARB_SETTLE = 16;  // pause-to-grant settle clocks after VBLANK rise

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_VBL = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_GRANT    = 3'd3,
    ST_ACC_WR   = 3'd4,
    ST_ACC_RD1  = 3'd5,
    ST_ACC_RD2  = 3'd6,
    ST_RELEASE  = 3'd7
  } arb_state_t;

endpackage

// File: rtl/hiscore_ram_arb_if.sv
// Bundle of CPU, HPS and RAM-port signals around the high-score arbiter.
// Latency: n/a (wiring only).
// Backpressure: HPS side is req/ack; CPU side is frozen through cpu_pause.
// Modports: slave = arbiter; master = surrounding core, HPS bridge and RAM.
interface hiscore_ram_arb_if #(
  parameter int AW = 10
);
  logic          VBLANK;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_we;
  logic          cpu_pause;
  logic          hs_req;
  logic [AW-1:0] hs_addr;
  logic [7:0]    hs_din;
  logic          hs_wr;
  logic          hs_rd;
  logic [7:0]    hs_dout;
  logic          hs_ack;
  logic          hs_grant;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [7:0]    ram_dout;

  modport slave (
    input  VBLANK, cpu_addr, cpu_din, cpu_we,
    input  hs_req, hs_addr, hs_din, hs_wr, hs_rd,
    input  ram_dout,
    output cpu_pause, hs_dout, hs_ack, hs_grant,
    output ram_addr, ram_din, ram_we
  );

  modport master (
    output VBLANK, cpu_addr, cpu_din, cpu_we,
    output hs_req, hs_addr, hs_din, hs_wr, hs_rd,
    output ram_dout,
    input  cpu_pause, hs_dout, hs_ack, hs_grant,
    input  ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/hiscore_ram_arb_rise_det.sv
// Rising-edge detector: flags the first clock a synchronous level is high.
// Latency: o_rise is combinational from i_sig against the registered previous level.
// Backpressure: none.
// Ports: i_clk, i_rst (sync, active high), i_sig level in, o_rise one-clock edge flag.
module rise_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);
  logic r_prev;

  // Reset to 1 so a level already high when reset lifts is not seen as an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= 1'b1;
    else       r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;
endmodule

// File: rtl/hiscore_ram_arb.sv
// Shares the single-port work RAM between the CPU and the HPS high-score channel.
// Latency: grant 1+SETTLE clocks after VBLANK rise; write ack t+1, read data/ack t+2.
// Backpressure: CPU frozen via cpu_pause while HPS owns the port; HPS waits for hs_ack.
// Ports: CLK, RESET (sync, active high), bus (slave modport: CPU, HPS and RAM sides).
module hiscore_ram_arb
  import hiscore_arb_pkg::*;
#(
  parameter int AW     = ARB_AW,
  parameter int SETTLE = ARB_SETTLE
) (
  input  logic              CLK,
  input  logic              RESET,
  hiscore_ram_arb_if.slave  bus
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  arb_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pause;
  logic          r_grant;
  logic          r_ack;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_din;
  logic [7:0]    r_dout;
  logic          w_vbl_rise;
  logic          w_hs_sel;

  rise_det u_vbl_rise (
    .i_clk  (CLK),
    .i_rst  (RESET),
    .i_sig  (bus.VBLANK),
    .o_rise (w_vbl_rise)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pause <= 1'b0;
      r_grant <= 1'b0;
      r_ack   <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_dout  <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.hs_req) r_state <= ST_WAIT_VBL;
        end
        ST_WAIT_VBL: begin
          if (!bus.hs_req) begin
            r_state <= ST_IDLE;
          end else if (w_vbl_rise) begin
            r_state <= ST_SETTLE;
            r_pause <= 1'b1;
            r_cnt   <= CW'(SETTLE - 1);
          end
        end
        ST_SETTLE: begin
          // Mux stays on the CPU here so a write issued before the pause lands.
          if (!bus.hs_req) begin
            r_state <= ST_RELEASE;
          end else if (r_cnt == '0) begin
            r_state <= ST_GRANT;
            r_grant <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_GRANT: begin
          // Write wins when both strobes arrive together.
          if (bus.hs_wr) begin
            r_state <= ST_ACC_WR;
            r_addr  <= bus.hs_addr;
            r_din   <= bus.hs_din;
            r_ack   <= 1'b1;
          end else if (bus.hs_rd) begin
            r_state <= ST_ACC_RD1;
            r_addr  <= bus.hs_addr;
          end else if (!bus.hs_req) begin
            r_state <= ST_RELEASE;
            r_grant <= 1'b0;
          end
        end
        ST_ACC_WR: begin
          if (!bus.hs_req) begin
            r_state <= ST_RELEASE;
            r_grant <= 1'b0;
          end else begin
            r_state <= ST_GRANT;
          end
        end
        ST_ACC_RD1: begin
          r_state <= ST_ACC_RD2;
          r_ack   <= 1'b1;
        end
        ST_ACC_RD2: begin
          r_dout <= bus.ram_dout;
          if (!bus.hs_req) begin
            r_state <= ST_RELEASE;
            r_grant <= 1'b0;
          end else begin
            r_state <= ST_GRANT;
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
          r_pause <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_pause <= 1'b0;
          r_grant <= 1'b0;
        end
      endcase
    end
  end

  assign w_hs_sel = (r_state == ST_GRANT)   || (r_state == ST_ACC_WR) ||
                    (r_state == ST_ACC_RD1) || (r_state == ST_ACC_RD2);

  assign bus.ram_addr  = w_hs_sel ? r_addr : bus.cpu_addr;
  assign bus.ram_din   = w_hs_sel ? r_din  : bus.cpu_din;
  assign bus.ram_we    = w_hs_sel ? (r_state == ST_ACC_WR) : bus.cpu_we;

  // RAM data is presented straight through on the ack clock, then held.
  assign bus.hs_dout   = (r_state == ST_ACC_RD2) ? bus.ram_dout : r_dout;
  assign bus.hs_ack    = r_ack;
  assign bus.hs_grant  = r_grant;
  assign bus.cpu_pause = r_pause;
endmodule

// File: tb/tb_hiscore_ram_arb.sv
module tb_hiscore_ram_arb;
  localparam int AW = 10;
  localparam int ST = 4;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  hiscore_ram_arb_if #(.AW(AW)) bus ();

  hiscore_ram_arb #(.AW(AW), .SETTLE(ST)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Synchronous RAM with one-clock read latency.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  // Reference: what each RAM byte should hold, from the accesses the bench made.
  logic [7:0] ref_mem [0:(1<<AW)-1];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input int n0, output int n);
    n = n0;
    while (bus.hs_grant !== 1'b1 && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic hs_write(input logic [AW-1:0] a, input logic [7:0] d, input logic both);
    bus.hs_addr = a; bus.hs_din = d; bus.hs_wr = 1'b1; bus.hs_rd = both;
    step();
    chk("wr_we",   bus.ram_we, 1);
    chk("wr_ack",  bus.hs_ack, 1);
    chk("wr_addr", bus.ram_addr, a);
    bus.hs_wr = 1'b0; bus.hs_rd = 1'b0;
    ref_mem[a] = d;
    step();
    chk("wr_ack_once", bus.hs_ack, 0);
  endtask

  task automatic hs_read(input logic [AW-1:0] a, input logic hold_rd);
    bus.hs_addr = a; bus.hs_rd = 1'b1;
    step();
    chk("rd1_ack",  bus.hs_ack, 0);
    chk("rd1_addr", bus.ram_addr, a);
    bus.hs_rd = hold_rd;
    step();
    bus.hs_rd = 1'b0;
    chk("rd2_ack",  bus.hs_ack, 1);
    chk("rd2_data", bus.hs_dout, ref_mem[a]);
    step();
    chk("rd_ack_once", bus.hs_ack, 0);
    chk("rd_hold",     bus.hs_dout, ref_mem[a]);
  endtask

  initial begin
    int n;
    logic [AW-1:0] a;
    logic [7:0] d;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    bus.VBLANK = 0; bus.cpu_addr = '0; bus.cpu_din = 0; bus.cpu_we = 0;
    bus.hs_req = 0; bus.hs_addr = '0; bus.hs_din = 0; bus.hs_wr = 0; bus.hs_rd = 0;

    // Reset state
    step(); step();
    bus.cpu_addr = 10'h2AA; bus.cpu_we = 1'b1; bus.cpu_din = 8'h3C;
    step();
    chk("rst_pause", bus.cpu_pause, 0);
    chk("rst_grant", bus.hs_grant, 0);
    chk("rst_ack",   bus.hs_ack, 0);
    chk("rst_dout",  bus.hs_dout, 0);
    chk("rst_we",    bus.ram_we, 1);
    chk("rst_addr",  bus.ram_addr, 10'h2AA);
    ref_mem[10'h2AA] = 8'h3C;
    RESET = 1'b0; bus.cpu_we = 1'b0;
    step(); step();

    // Abort in WAIT_VBL
    bus.hs_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_pause", bus.cpu_pause, 0);
    end
    bus.hs_req = 1'b0;
    step(); step();
    bus.cpu_addr = 10'h155;
    #1;
    chk("abort_pause_end", bus.cpu_pause, 0);
    chk("abort_mux_cpu",   bus.ram_addr, 10'h155);

    // Grant with a CPU write one clock after the VBLANK rise
    bus.hs_req = 1'b1;
    step(); step(); step();
    chk("wait_pause", bus.cpu_pause, 0);
    bus.VBLANK = 1'b1;
    step();
    chk("settle_pause", bus.cpu_pause, 1);
    chk("settle_grant", bus.hs_grant, 0);
    bus.cpu_addr = 10'h010; bus.cpu_din = 8'h12; bus.cpu_we = 1'b1;
    #1;
    chk("settle_cpu_we", bus.ram_we, 1);
    step();
    bus.cpu_we = 1'b0;
    ref_mem[10'h010] = 8'h12;
    wait_grant(2, n);
    chk("grant_latency", n, ST + 1);

    hs_write(10'h3F0, 8'hA5, 1'b0);
    hs_read(10'h3F0, 1'b0);
    hs_read(10'h010, 1'b0);
    hs_write(10'h0C3, 8'h5A, 1'b1);   // wr+rd together -> write
    hs_read(10'h0C3, 1'b1);           // rd held into ACC_RD1 -> ignored
    chk("grant_hold", bus.hs_grant, 1);
    chk("pause_hold", bus.cpu_pause, 1);

    // Randomized accesses against the reference memory
    for (int i = 0; i < 24; i++) begin
      a = AW'($urandom_range(0, (1 << AW) - 1));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) hs_write(a, d, 1'($urandom_range(0, 1)));
      else                          hs_read(a, 1'b0);
    end

    // Release sequencing
    bus.hs_req = 1'b0;
    step();
    chk("rel_grant_t1", bus.hs_grant, 0);
    chk("rel_pause_t1", bus.cpu_pause, 1);
    bus.cpu_addr = 10'h020; bus.cpu_din = 8'h77; bus.cpu_we = 1'b1;
    #1;
    chk("rel_cpu_we",   bus.ram_we, 1);
    chk("rel_cpu_addr", bus.ram_addr, 10'h020);
    step();
    bus.cpu_we = 1'b0;
    ref_mem[10'h020] = 8'h77;
    chk("rel_pause_t2", bus.cpu_pause, 0);

    // VBLANK already high at request: waits for the next rise
    step();
    bus.hs_req = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("vhigh_pause", bus.cpu_pause, 0);
    bus.VBLANK = 1'b0;
    step();
    bus.VBLANK = 1'b1;
    step();
    wait_grant(1, n);
    chk("grant_latency2", n, ST + 1);
    hs_read(10'h020, 1'b0);
    hs_read(10'h2AA, 1'b0);

    // Reset during ACC_RD1
    bus.hs_addr = 10'h3F0; bus.hs_rd = 1'b1; bus.cpu_addr = 10'h155;
    step();
    chk("rstm_rd1_addr", bus.ram_addr, 10'h3F0);
    bus.hs_rd = 1'b0; RESET = 1'b1;
    step();
    chk("rstm_pause", bus.cpu_pause, 0);
    chk("rstm_grant", bus.hs_grant, 0);
    chk("rstm_ack",   bus.hs_ack, 0);
    chk("rstm_mux",   bus.ram_addr, 10'h155);
    RESET = 1'b0; bus.hs_req = 1'b0;
    step();
    chk("rstm_ack2", bus.hs_ack, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
